// File: rtl/count_ones_sequencer.sv
// rtl/count_ones_sequencer.sv - multi-cycle chunked popcount with valid/ready handshakes
module count_ones_sequencer #(
   parameter int WIDTH       = 64,
   parameter int CHUNK_WIDTH = 8,
   parameter int CHUNK_COUNT = WIDTH / CHUNK_WIDTH,
   parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic [WIDTH-1:0]       input_data,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [COUNT_WIDTH-1:0] output_count,
   output logic                   busy
);

   // A single-chunk configuration still needs a one-bit index register.
   localparam int IDX_WIDTH = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHUNK_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       shift_q, shift_d;
   logic [COUNT_WIDTH-1:0] acc_q, acc_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;

   logic [COUNT_WIDTH-1:0] chunk_ones;
   logic [WIDTH-1:0]       remainder;
   logic                   last_chunk;

   // Ones in the low chunk, already zero-extended to the accumulator width.
   always_comb begin
      chunk_ones = '0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
         chunk_ones = chunk_ones + COUNT_WIDTH'(shift_q[i]);
      end
   end

   // Stop after the final chunk, or as soon as nothing but zeros is left to walk.
   always_comb begin
      remainder  = shift_q >> CHUNK_WIDTH;
      last_chunk = (idx_q == LAST_IDX) || (remainder == '0);
   end

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (input_valid) state_d = ST_COUNT;
         ST_COUNT: if (last_chunk) state_d = ST_DONE;
         ST_DONE:  if (output_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Handshake flags are pure state decodes, so no input reaches an output combinationally.
   always_comb begin
      input_ready  = (state_q == ST_IDLE);
      output_valid = (state_q == ST_DONE);
      busy         = (state_q != ST_IDLE);
   end

   // Datapath next values: load on accept, accumulate and shift while counting, hold otherwise.
   always_comb begin
      shift_d = shift_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (input_valid) begin
               shift_d = input_data;
               acc_d   = '0;
               idx_d   = '0;
            end
         end
         ST_COUNT: begin
            acc_d   = acc_q + chunk_ones;
            shift_d = remainder;
            idx_d   = idx_q + IDX_WIDTH'(1);
         end
         default: begin
            shift_d = shift_q;
         end
      endcase
   end

   // Datapath registers; the accumulator doubles as the registered result.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         shift_q <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
      end
   end

   assign output_count = acc_q;

endmodule

// File: tb/tb_count_ones_sequencer.sv
// tb/tb_count_ones_sequencer.sv - scoreboard bench for count_ones_sequencer
module tb_count_ones_sequencer;

   logic        clock;
   logic        resetn;
   logic        input_valid;
   logic        input_ready;
   logic [31:0] input_data;
   logic        output_valid;
   logic        output_ready;
   logic [5:0]  output_count;
   logic        busy;

   count_ones_sequencer #(.WIDTH(32), .CHUNK_WIDTH(8)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_count (output_count),
      .busy         (busy)
   );

   typedef struct {
      int cnt;
      int k;
      int edge_c;
   } exp_t;

   exp_t sb_q[$];
   int   hs_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pushes = 0;
   int   flushed = 0;
   int   last_result = -1;
   bit   prev_valid = 0;
   bit   prev_ready = 0;
   int   prev_count = 0;
   bit   rdy_mode = 0;
   bit   rdy_force = 0;
   int   rdy_duty = 60;

   initial clock = 0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: popcount and number of chunks walked, from plain arithmetic.
   function automatic int ref_count(input logic [31:0] w);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'((w >> i) & 32'd1);
      return n;
   endfunction

   function automatic int ref_k(input logic [31:0] w);
      int k = 1;
      for (int i = 0; i < 4; i++) if (((w >> (8 * i)) & 32'hFF) != 0) k = i + 1;
      return k;
   endfunction

   // Consumer-side ready generator.
   always @(posedge clock) begin
      #2;
      if (rdy_mode) output_ready = ($urandom_range(0, 99) < rdy_duty);
      else          output_ready = rdy_force;
   end

   // Monitor: samples mid-cycle, pushes expectations on accept, pops on result handshake.
   always @(negedge clock) begin
      if (resetn) begin
         if (input_valid && input_ready) begin
            sb_q.push_back('{ref_count(input_data), ref_k(input_data), cyc + 1});
            pushes++;
         end
         if (output_valid && !prev_valid) begin
            if (sb_q.size() == 0) check("unexpected_result", 1, 0);
            else check("latency_k", cyc - sb_q[0].edge_c, sb_q[0].k);
         end
         if (prev_valid && !prev_ready) begin
            check("hold_valid", output_valid, 1);
            check("hold_count", output_count, prev_count);
         end
         if (output_valid && output_ready) begin
            if (sb_q.size() == 0) begin
               check("duplicate_result", 1, 0);
            end else begin
               check("result_count", output_count, sb_q[0].cnt);
               void'(sb_q.pop_front());
            end
            hs_log.push_back(cyc);
            last_result = int'(output_count);
         end
         prev_valid = output_valid;
         prev_ready = output_ready;
         prev_count = int'(output_count);
      end else begin
         prev_valid = 0;
         prev_ready = 0;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] w, input bit keep);
      int n = 0;
      input_valid = 1;
      input_data  = w;
      @(negedge clock);
      while (!input_ready && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (!input_ready) check("send_timeout", 0, 1);
      @(posedge clock);
      #1;
      if (!keep) input_valid = 0;
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((sb_q.size() != 0 || busy) && n < limit) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (sb_q.size() != 0 || busy) check("drain_timeout", 0, 1);
   endtask

   initial begin
      int base;
      int n;
      logic [31:0] w;
      resetn       = 0;
      input_valid  = 0;
      input_data   = '0;
      output_ready = 0;
      #1;
      check("rst_input_ready", input_ready, 1);
      check("rst_output_valid", output_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_output_count", output_count, 0);
      repeat (2) @(posedge clock);
      #1 resetn = 1;

      // Directed words with ready held high.
      rdy_force = 1;
      @(posedge clock); #1;
      send(32'hFFFFFFFF, 0); wait_drain(100);
      check("full_word_result", last_result, 32);
      send(32'h00000000, 0); wait_drain(100);
      check("zero_word_result", last_result, 0);
      send(32'h00000F01, 0); wait_drain(100);
      check("early_term_result", last_result, 5);
      send(32'h80000000, 0); wait_drain(100);
      check("top_bit_result", last_result, 1);

      // Backpressure with an ignored input pulse.
      rdy_force = 0;
      base = hs_log.size();
      send(32'h000000A5, 0);
      n = 0;
      while (!output_valid && n < 50) begin
         @(posedge clock); #1; n++;
      end
      check("bp_reached_done", output_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_valid", output_valid, 1);
         check("bp_count", output_count, 4);
         check("bp_input_ready", input_ready, 0);
         check("bp_busy", busy, 1);
         @(posedge clock); #1;
         input_valid = (i == 1);
         input_data  = 32'hFFFFFFFF;
      end
      input_valid = 0;
      rdy_force = 1;
      wait_drain(100);
      repeat (3) @(posedge clock);
      #1;
      check("bp_single_result", hs_log.size() - base, 1);

      // Back-to-back with input_valid held high.
      base = hs_log.size();
      send(32'h0000000F, 1);
      send(32'h0F0F0F0F, 1);
      send(32'hFFFF0000, 0);
      wait_drain(100);
      check("b2b_results", hs_log.size() - base, 3);
      if (hs_log.size() - base == 3) begin
         check("b2b_interval_2", hs_log[base + 1] - hs_log[base], 6);
         check("b2b_interval_3", hs_log[base + 2] - hs_log[base + 1], 6);
      end
      check("b2b_last_result", last_result, 16);

      // Reset during the third COUNT cycle.
      base = hs_log.size();
      send(32'hFFFFFFFF, 0);
      @(posedge clock); #2;
      @(posedge clock); #2;
      resetn = 0;
      flushed += sb_q.size();
      sb_q.delete();
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_output_valid", output_valid, 0);
      check("midrst_input_ready", input_ready, 1);
      @(posedge clock); #1;
      resetn = 1;
      send(32'h00000003, 0);
      wait_drain(100);
      repeat (3) @(posedge clock);
      #1;
      check("post_rst_results", hs_log.size() - base, 1);
      check("post_rst_value", last_result, 2);

      // Randomized cross-check.
      rdy_mode = 1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clock); #1;
         end
         case ($urandom_range(0, 3))
            0: w = $urandom;
            1: w = $urandom & (32'hFFFFFFFF >> (8 * $urandom_range(0, 3)));
            2: w = 32'h0;
            default: w = 32'h1 << $urandom_range(0, 31);
         endcase
         send(w, 0);
      end
      wait_drain(2000);
      rdy_mode = 0;
      check("final_queue_empty", sb_q.size(), 0);
      check("no_drop_no_dup", hs_log.size(), pushes - flushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_ones_sequencer.md
# count_ones_sequencer

Multi-cycle population counter for wide vectors. It accepts one `WIDTH`-bit word per valid/ready handshake. It then walks the word `CHUNK_WIDTH` bits per cycle through a single narrow ones-counter and accumulates the partial counts. It returns the total through a second valid/ready handshake. It is used where a full-width combinational popcount misses timing or costs too much area, for example in allocation bitmaps, occupancy masks and error-bit tallies.

## Interface

- `WIDTH`, default 64: input vector width. Must be a multiple of `CHUNK_WIDTH`.
- `CHUNK_WIDTH`, default 8: bits counted per cycle, which is the width of the internal ones-counter.
- `CHUNK_COUNT`, default `WIDTH/CHUNK_WIDTH`: number of chunks. Derived; do not override.
- `COUNT_WIDTH`, default `CLOG2(WIDTH+1)`: result width. Must hold the value `WIDTH` when all bits are set.
- `clock` input, 1 bit: the single clock. All state updates on its rising edge.
- `resetn` input, 1 bit: reset. Asynchronous, active-low.
- `input_valid` input, 1 bit: `input_data` is presented.
- `input_ready` output, 1 bit: block can accept a word.
- `input_data` input, `WIDTH` bits: vector to count.
- `output_valid` output, 1 bit: `output_count` holds a result.
- `output_ready` input, 1 bit: consumer accepts the result.
- `output_count` output, `COUNT_WIDTH` bits: number of set bits in the accepted word.
- `busy` output, 1 bit: high whenever state is not IDLE.

## Operation

- State machine has three states:
  - **IDLE**:
    - `input_ready`=1.
    - On `input_valid`&`input_ready`: capture `input_data` into the shift register, clear the accumulator, set the chunk index to 0, go to COUNT.
  - **COUNT**, every cycle:
    - Accumulator += popcount(shift register[`CHUNK_WIDTH`-1:0]).
    - Shift register >>= `CHUNK_WIDTH`, zero-filled.
    - Chunk index += 1.
    - Go to DONE if chunk index == `CHUNK_COUNT`-1, or if the shifted-out remainder (shift register >> `CHUNK_WIDTH`) is all-zero (early termination). Otherwise stay in COUNT.
  - **DONE**:
    - `output_valid`=1.
    - `output_count`=accumulator.
    - On `output_ready`, go to IDLE.
- `input_ready` is 0 in COUNT and DONE. Words offered in those states are not accepted; there is no input buffering.
- Accumulator is `COUNT_WIDTH` bits and cannot overflow, because its maximum value is `WIDTH`.
- Each partial count is zero-extended to `COUNT_WIDTH` before the add.
- `CHUNK_COUNT`==1 is legal: COUNT lasts exactly 1 cycle.
- `output_count` is held stable and `output_valid` stays high until `output_ready` is seen. No drop or change is allowed under backpressure.
- `output_count` shows the accumulator in all states, but its value is meaningful only when `output_valid`=1.

## Timing

- Reset (asynchronous assert, synchronous release):
  - State=IDLE.
  - `input_ready`=1 immediately on assert, because it is decoded from state.
  - `output_valid`=0, `busy`=0, `output_count`=0.
  - Shift register, accumulator and index all reset to 0.
- Reset mid-COUNT or mid-DONE: the in-flight word and its result are discarded. `output_valid` goes 0 immediately. No result is emitted after release.
- Latency:
  - Input handshake at edge E.
  - COUNT occupies edges E+1..E+K, where K = 1 + index of the highest non-zero chunk. K=1 for an all-zero word. K is at most `CHUNK_COUNT`.
  - `output_valid` rises after edge E+K.
- Output handshake at edge D returns the block to IDLE. `input_ready` is 1 in the following cycle. The earliest next accept is edge D+1.
- Sustained throughput with `output_ready` tied high: one word per K+2 cycles.
- `input_valid` asserted in the same cycle as the `output_ready` handshake is not accepted, because the block is in DONE. It is accepted one cycle later.
- No combinational path from any input to any output.
  - `input_ready`, `output_valid` and `busy` are decoded from state.
  - `output_count` is registered.

## Test plan

- WIDTH=32, CHUNK_WIDTH=8, input 0xFFFFFFFF, `output_ready`=1 -> 4 COUNT cycles, then `output_count`=32 with `output_valid`=1 for 1 cycle. Checks the full-width boundary and that `COUNT_WIDTH`=6 holds 32.
- Input 0x00000000 -> 1 COUNT cycle, `output_count`=0. Input 0x00000F01 -> 2 COUNT cycles (early termination after chunk 1), `output_count`=5. Input 0x80000000 -> 4 COUNT cycles, `output_count`=1.
- Backpressure: result 0xA5 present, `output_ready`=0 for 5 cycles -> `output_valid` stays 1, `output_count`=4 stays stable, `input_ready`=0 and `busy`=1 throughout. An `input_valid` pulse during this window is ignored.
- Back-to-back: `input_valid` held high with words 0x0000000F, 0x0F0F0F0F, 0xFFFF0000 and `output_ready`=1 -> results 4, 16, 16 in order, at intervals of K+2 cycles (3, 6, 6).
- Reset: assert `resetn`=0 during the 3rd COUNT cycle of 0xFFFFFFFF -> `busy`=0, `output_valid`=0 and `input_ready`=1 without waiting for a clock edge. After release, the next word 0x00000003 yields exactly one result, 2, with no stale result.
- Randomized cross-check: 1000 random words with random `input_valid` and `output_ready` duty cycles. Every result must match a reference popcount, and no result may be dropped or duplicated.
